// File: rtl/score_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | score_tracker: apple-event score counter with best-score hold, play/over   |
// | state machine and divided scroll clock for the scoreboard display.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module score_tracker #(
  parameter int MAX_SIZE   = 255,
  parameter int SCROLL_DIV = 12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       appleEaten,
  input  logic       gameOver,
  input  logic       clearHigh,
  output logic [7:0] size,
  output logic [7:0] highScore,
  output logic       newRecord,
  output logic       playing,
  output logic       screenClock
);

  localparam int                 c_CNT_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(SCROLL_DIV - 1);
  localparam logic [7:0]         c_MAX      = 8'(MAX_SIZE);

  typedef enum logic [1:0] {
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t             r_state;
  logic               r_apple_prev;
  logic [c_CNT_W-1:0] r_div_cnt;
  // Best score survives ordinary resets, so it powers up cleared instead.
  logic [7:0]         r_high_score = 8'd0;
  logic               w_apple_event;

  assign w_apple_event = appleEaten & ~r_apple_prev;
  assign highScore     = r_high_score;

  always_ff @(posedge clock) begin
    r_apple_prev <= reset ? 1'b0 : appleEaten;
    if (reset) begin
      r_state     <= PLAY;
      size        <= 8'd0;
      newRecord   <= 1'b0;
      playing     <= 1'b1;
      screenClock <= 1'b0;
      r_div_cnt   <= '0;
      if (clearHigh) begin
        r_high_score <= 8'd0;
      end
    end else begin
      if (r_div_cnt == c_DIV_LAST) begin
        r_div_cnt   <= '0;
        screenClock <= ~screenClock;
      end else begin
        r_div_cnt <= r_div_cnt + c_CNT_W'(1);
      end

      case (r_state)
        PLAY: begin
          // Game over takes priority over a coincident apple event.
          if (gameOver) begin
            r_state   <= OVER;
            playing   <= 1'b0;
            newRecord <= (size > r_high_score);
            if (size > r_high_score) begin
              r_high_score <= size;
            end
          end else if (w_apple_event && (size < c_MAX)) begin
            size <= size + 8'd1;
          end
        end
        OVER: begin
          r_state <= OVER;
        end
        default: begin
          r_state <= PLAY;
          playing <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_tracker.sv
`default_nettype none
// Testbench for score_tracker: two instances (wide/slow divider and saturating/fast
// divider) share stimulus; expectations are queued and checked on the falling edge.
module tb_score_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       apple = 1'b0;
  logic       gover = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] size_a, hs_a, size_b, hs_b;
  logic       nr_a, play_a, sc_a, nr_b, play_b, sc_b;

  always #5 clk = ~clk;

  score_tracker #(.MAX_SIZE(255), .SCROLL_DIV(4)) dut (
    .clock(clk), .reset(rst), .appleEaten(apple), .gameOver(gover), .clearHigh(clr),
    .size(size_a), .highScore(hs_a), .newRecord(nr_a), .playing(play_a), .screenClock(sc_a)
  );

  score_tracker #(.MAX_SIZE(5), .SCROLL_DIV(1)) dut_sat (
    .clock(clk), .reset(rst), .appleEaten(apple), .gameOver(gover), .clearHigh(clr),
    .size(size_b), .highScore(hs_b), .newRecord(nr_b), .playing(play_b), .screenClock(sc_b)
  );

  typedef struct {
    int    due;
    int    id;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Models: a_* for the 255/4 instance, b_* for the 5/1 instance.
  int a_size = 0, a_hs = 0, a_nr = 0, a_play = 1;
  int b_size = 0, b_hs = 0, b_nr = 0, b_play = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] get_sig(input int id);
    case (id)
      0: return {24'd0, size_a};
      1: return {24'd0, hs_a};
      2: return {31'd0, nr_a};
      3: return {31'd0, play_a};
      4: return {31'd0, sc_a};
      5: return {24'd0, size_b};
      6: return {24'd0, hs_b};
      7: return {31'd0, nr_b};
      8: return {31'd0, play_b};
      default: return {31'd0, sc_b};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < cyc) begin
        check({sb[i].tag, "_missed"}, 32'd1, 32'd0);
        sb.delete(i);
      end else if (sb[i].due == cyc) begin
        check(sb[i].tag, get_sig(sb[i].id), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic push_exp(input int dly, input string tag, input int id, input int val);
    exp_t e;
    e.due = cyc + dly;
    e.id  = id;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_state(input int dly, input string tag);
    push_exp(dly, {tag, "_size_a"}, 0, a_size);
    push_exp(dly, {tag, "_hs_a"},   1, a_hs);
    push_exp(dly, {tag, "_nr_a"},   2, a_nr);
    push_exp(dly, {tag, "_play_a"}, 3, a_play);
    push_exp(dly, {tag, "_size_b"}, 5, b_size);
    push_exp(dly, {tag, "_hs_b"},   6, b_hs);
    push_exp(dly, {tag, "_nr_b"},   7, b_nr);
    push_exp(dly, {tag, "_play_b"}, 8, b_play);
  endtask

  task automatic do_reset(input bit clear, input bit apple_in, input string tag);
    rst = 1'b1; clr = clear; apple = apple_in; gover = 1'b0;
    a_size = 0; a_nr = 0; a_play = 1;
    b_size = 0; b_nr = 0; b_play = 1;
    if (clear) begin
      a_hs = 0;
      b_hs = 0;
    end
    push_state(1, tag);
    push_exp(1, {tag, "_sc_a"}, 4, 0);
    push_exp(1, {tag, "_sc_b"}, 9, 0);
    tick();
    rst = 1'b0; clr = 1'b0;
  endtask

  task automatic apple_pulse(input int len, input int gap, input string tag);
    apple = 1'b1;
    if (a_play == 1 && a_size < 255) a_size++;
    if (b_play == 1 && b_size < 5) b_size++;
    push_exp(1, {tag, "_size_a"}, 0, a_size);
    push_exp(1, {tag, "_size_b"}, 5, b_size);
    if (len > 1) begin
      push_exp(len, {tag, "_hold_a"}, 0, a_size);
      push_exp(len, {tag, "_hold_b"}, 5, b_size);
    end
    repeat (len) tick();
    apple = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic game_over(input string tag);
    gover = 1'b1;
    if (a_play == 1) begin
      a_nr = (a_size > a_hs) ? 1 : 0;
      if (a_size > a_hs) a_hs = a_size;
      a_play = 0;
    end
    if (b_play == 1) begin
      b_nr = (b_size > b_hs) ? 1 : 0;
      if (b_size > b_hs) b_hs = b_size;
      b_play = 0;
    end
    push_state(1, tag);
    tick();
  endtask

  initial begin
    int e;
    tick();
    // Reset values, two cycles with clearHigh.
    rst = 1'b1; clr = 1'b1;
    tick();
    do_reset(1'b1, 1'b0, "reset");

    // Three short pulses 5 apart, then a 10-cycle level: counts 4.
    for (int i = 0; i < 3; i++) apple_pulse(1, 4, "pulse");
    apple_pulse(10, 2, "long");
    // Three more: wide instance reaches 7, saturating one sticks at 5.
    for (int i = 0; i < 3; i++) apple_pulse(1, 2, "sat");
    game_over("over7");
    apple_pulse(1, 2, "after_over");
    push_state(1, "over_hold");
    tick();

    // Lower score without clearing best.
    do_reset(1'b0, 1'b0, "rst_keep");
    for (int i = 0; i < 4; i++) apple_pulse(1, 1, "score4");
    game_over("over4");

    // Tie with the best score is not a record.
    do_reset(1'b0, 1'b0, "rst_tie");
    for (int i = 0; i < 7; i++) apple_pulse(2, 1, "score7");
    game_over("tie");

    // Apple held through reset counts once afterwards; then apple and game over together.
    do_reset(1'b1, 1'b1, "rst_apple");
    a_size = 1; b_size = 1;
    push_exp(1, "held_size_a", 0, 1);
    push_exp(3, "held_keep_a", 0, 1);
    push_exp(3, "held_keep_b", 5, 1);
    repeat (3) tick();
    apple = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) apple_pulse(1, 1, "score3");
    apple = 1'b1;
    game_over("simul");
    apple = 1'b0;
    tick();

    // Divider: rises 4 edges after reset with period 8; reset on edge 6 restarts it.
    do_reset(1'b0, 1'b0, "rst_div");
    e = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        rst = 1'b1;
        e = 0;
        push_exp(1, "div_rst_a", 4, 0);
        push_exp(1, "div_rst_b", 9, 0);
      end else begin
        e++;
        push_exp(1, "div_a", 4, (e / 4) % 2);
        push_exp(1, "div_b", 9, e % 2);
      end
      tick();
      rst = 1'b0;
    end

    repeat (3) tick();
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
